// File: rtl/affine3_act1.sv
// rtl/affine3_act1.sv - ReLU/shift/clip quantizer packing activations into ping-pong vector buffers
// Optional saturation counter: AFFINE3_SAT_CNT_EN
module affine3_act1 #(
    parameter int NUM_NEURON = 16,
    parameter int IN_WIDTH   = 10,
    parameter int OUT_WIDTH  = 6,
    parameter int SHIFT      = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [IN_WIDTH-1:0]             sum_in,
    input  logic                            sum_valid,
    output logic                            sum_ready,
    output logic [NUM_NEURON*OUT_WIDTH-1:0] vec_out,
    output logic                            vec_valid,
    input  logic                            vec_ready
`ifdef AFFINE3_SAT_CNT_EN
    ,
    output logic [7:0]                      sat_count
`endif
);

    localparam int CNT_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
    localparam int VEC_W = NUM_NEURON * OUT_WIDTH;
    localparam logic [IN_WIDTH-1:0] MAX_Q = IN_WIDTH'((1 << OUT_WIDTH) - 1);
    localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(NUM_NEURON - 1);

    logic [1:0]       r_full;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [VEC_W-1:0] r_buf [2];

    logic                 w_accept;
    logic                 w_drain;
    logic                 w_last;
    logic                 w_neg;
    logic                 w_clip;
    logic [IN_WIDTH-1:0]  w_shifted;
    logic [OUT_WIDTH-1:0] w_q;

    // Sign bit selects ReLU; shift only matters for non-negative sums
    assign w_neg     = sum_in[IN_WIDTH-1];
    assign w_shifted = sum_in >> SHIFT;
    assign w_clip    = !w_neg && (w_shifted > MAX_Q);
    assign w_q       = w_neg  ? '0 :
                       w_clip ? '1 : w_shifted[OUT_WIDTH-1:0];

    assign sum_ready = !r_full[r_wr_sel];
    assign vec_valid = r_full[r_rd_sel];
    assign vec_out   = r_buf[r_rd_sel];

    assign w_accept  = sum_valid && sum_ready;
    assign w_drain   = vec_valid && vec_ready;
    assign w_last    = (r_cnt == LAST_IDX);

    // Accept needs the write buffer empty and drain needs the read buffer full,
    // so a simultaneous fill-complete and drain always touch different r_full bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_full   <= 2'b00;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_cnt    <= '0;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else begin
            if (w_accept) begin
                r_buf[r_wr_sel][int'(r_cnt)*OUT_WIDTH +: OUT_WIDTH] <= w_q;
                if (w_last) begin
                    r_cnt            <= '0;
                    r_full[r_wr_sel] <= 1'b1;
                    r_wr_sel         <= ~r_wr_sel;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_drain) begin
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= ~r_rd_sel;
            end
        end
    end

`ifdef AFFINE3_SAT_CNT_EN
    logic [7:0] r_sat_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_count <= 8'd0;
        end else if (w_accept && w_clip && (r_sat_count != 8'hFF)) begin
            r_sat_count <= r_sat_count + 8'd1;
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_affine3_act1.sv
// tb/tb_affine3_act1.sv - randomized and directed checks of affine3_act1 against a queue-based model
module tb_affine3_act1;

    logic        clock;
    logic        reset_n;
    logic [9:0]  sum_in;
    logic        sum_valid;
    logic        sum_ready;
    logic [95:0] vec_out;
    logic        vec_valid;
    logic        vec_ready;
`ifdef AFFINE3_SAT_CNT_EN
    logic [7:0]  sat_count;
`endif

    affine3_act1 dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready)
`ifdef AFFINE3_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [95:0] done_q[$];
    int          partial_q[$];
    int          sat_model;
    bit          obs_ready;

    function automatic int quant(input logic [9:0] s);
        int si;
        int v;
        si = int'($signed(s));
        if (si < 0) return 0;
        v = si / 4;
        return (v > 63) ? 63 : v;
    endfunction

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        done_q.delete();
        partial_q.delete();
        sat_model = 0;
    endtask

    task automatic do_reset();
        sum_valid = 1'b0;
        vec_ready = 1'b0;
        sum_in    = '0;
        #2 reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input bit v, input logic [9:0] s, input bit vr);
        bit          acc;
        bit          drn;
        logic [95:0] vec;
        sum_valid = v;
        sum_in    = s;
        vec_ready = vr;
        #1;
        obs_ready = sum_ready;
        chk("sum_ready", 96'(sum_ready), 96'(done_q.size() < 2));
        chk("vec_valid", 96'(vec_valid), 96'(done_q.size() > 0));
        if (done_q.size() > 0) chk("vec_out", vec_out, done_q[0]);
`ifdef AFFINE3_SAT_CNT_EN
        chk("sat_count", 96'(sat_count), 96'(sat_model));
`endif
        acc = v && (done_q.size() < 2);
        drn = vr && (done_q.size() > 0);
        @(posedge clock);
        #1;
        if (drn) void'(done_q.pop_front());
        if (acc) begin
            if (int'($signed(s)) >= 0 && int'($signed(s)) / 4 > 63 && sat_model < 255)
                sat_model++;
            partial_q.push_back(quant(s));
            if (partial_q.size() == 16) begin
                vec = '0;
                for (int k = 0; k < 16; k++) vec[k*6 +: 6] = 6'(partial_q[k]);
                done_q.push_back(vec);
                partial_q.delete();
            end
        end
    endtask

    initial begin
        int          dir_sums[16];
        logic [95:0] exp_vec;
        int          n_acc;

        reset_n   = 1'b1;
        sum_valid = 1'b0;
        vec_ready = 1'b0;
        sum_in    = '0;
        do_reset();

        // Reset state
        chk("reset_sum_ready", 96'(sum_ready), 96'd1);
        chk("reset_vec_valid", 96'(vec_valid), 96'd0);
        chk("reset_vec_out", vec_out, 96'd0);

        // Directed quantize vector
        dir_sums = '{100, 300, -5, 255, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) step(1'b1, 10'(dir_sums[i]), 1'b1);
        exp_vec = '0;
        exp_vec[0*6 +: 6] = 6'd25;
        exp_vec[1*6 +: 6] = 6'd63;
        exp_vec[2*6 +: 6] = 6'd0;
        exp_vec[3*6 +: 6] = 6'd63;
        exp_vec[4*6 +: 6] = 6'd0;
        chk("quant_valid", 96'(vec_valid), 96'd1);
        chk("quant_vector", vec_out, exp_vec);
        step(1'b0, '0, 1'b1);
        chk("quant_drained", 96'(vec_valid), 96'd0);

        // Backpressure: 40 offered sums, only 32 fit
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 10'($urandom_range(0, 1023)), 1'b0);
            if (obs_ready) n_acc++;
        end
        chk("bp_accepts", 96'(n_acc), 96'd32);
        chk("bp_ready_low", 96'(sum_ready), 96'd0);
        step(1'b1, 10'd400, 1'b1);
        chk("bp_ready_back", 96'(sum_ready), 96'd1);
        step(1'b0, '0, 1'b1);
        chk("bp_all_drained", 96'(vec_valid), 96'd0);

        // Overlap: vector B completes in the same cycle vector A drains
        for (int i = 0; i < 16; i++) step(1'b1, 10'($urandom_range(0, 1023)), 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 10'($urandom_range(0, 1023)), 1'b0);
        step(1'b1, 10'd200, 1'b1);
        chk("overlap_valid", 96'(vec_valid), 96'd1);
        chk("overlap_ready", 96'(sum_ready), 96'd1);
        step(1'b0, '0, 1'b1);
        chk("overlap_empty", 96'(vec_valid), 96'd0);

        // Reset mid-fill
        for (int i = 0; i < 7; i++) step(1'b1, 10'($urandom_range(0, 1023)), 1'b0);
        do_reset();
        chk("midrst_vec_valid", 96'(vec_valid), 96'd0);
        chk("midrst_vec_out", vec_out, 96'd0);
        chk("midrst_sum_ready", 96'(sum_ready), 96'd1);
        for (int i = 0; i < 16; i++) step(1'b1, 10'($urandom_range(0, 1023)), 1'b0);
        chk("midrst_clean_valid", 96'(vec_valid), 96'd1);
        step(1'b0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 2) != 0));

`ifdef AFFINE3_SAT_CNT_EN
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 10'd511, 1'b1);
        chk("sat_max", 96'(sat_count), 96'd255);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 10'h200, 1'b1);
        chk("sat_negative", 96'(sat_count), 96'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
